// File: rtl/tri_fu_mul_bthseq_pkg.sv
// tri_fu_mul_bthseq_pkg: FSM state encoding, Booth triplet decode and cycle-count helper
//   state_t   IDLE=2'b00, BUSY=2'b01, DONE=2'b10
//   booth_t   {sneg, sx, sx2} row controls for one radix-4 digit
package tri_fu_mul_bthseq_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
  typedef struct packed {
    logic sneg;
    logic sx;
    logic sx2;
  } booth_t;
  function automatic booth_t booth_dec(input logic [2:0] t);
    booth_t d;
    d.sneg = t[2] & ~(t[1] & t[0]);
    d.sx = t[1] ^ t[0];
    d.sx2 = (t == 3'b011) | (t == 3'b100);
    return d;
  endfunction
  function automatic int ncyc(input int width, input int rows);
    return width / (2 * rows);
  endfunction
endpackage

// File: rtl/tri_fu_mul_bthseq_if.sv
// tri_fu_mul_bthseq_if: operand/product valid-ready bus plus flush
//   master drives flush, i_vld, i_a, i_b, (i_c), o_rdy; slave drives i_rdy, o_vld, o_p
//   i_c exists only when TRI_FU_MUL_BTHSEQ_ACC_EN is defined
interface tri_fu_mul_bthseq_if #(parameter int WIDTH = 16);
  logic flush;
  logic i_vld;
  logic i_rdy;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
`ifdef TRI_FU_MUL_BTHSEQ_ACC_EN
  logic [2*WIDTH-1:0] i_c;
`endif
  logic o_vld;
  logic o_rdy;
  logic [2*WIDTH-1:0] o_p;
  modport master (
`ifdef TRI_FU_MUL_BTHSEQ_ACC_EN
    output i_c,
`endif
    output flush, i_vld, i_a, i_b, o_rdy,
    input i_rdy, o_vld, o_p
  );
  modport slave (
`ifdef TRI_FU_MUL_BTHSEQ_ACC_EN
    input i_c,
`endif
    input flush, i_vld, i_a, i_b, o_rdy,
    output i_rdy, o_vld, o_p
  );
endinterface

// File: rtl/tri_fu_mul_bthseq_bthrow.sv
// tri_fu_mul_bthseq_bthrow: one Booth row, triplet decode plus per-bit mux of a / 2a, conditionally inverted
//   trip  in   multiplier triplet b[2j+1:2j-1]
//   a     in   multiplicand sign-extended to WIDTH+2
//   row   out  selected multiple, ones-complemented when negative
//   sneg  out  +1 carry-in that completes the two's-complement negation
module tri_fu_mul_bthseq_bthrow
  import tri_fu_mul_bthseq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       trip,
  input  logic [WIDTH+1:0] a,
  output logic [WIDTH+1:0] row,
  output logic             sneg
);
  booth_t d;
  assign d = booth_dec(trip);
  assign sneg = d.sneg;
  assign row = (({(WIDTH+2){d.sx}} & a) | ({(WIDTH+2){d.sx2}} & {a[WIDTH:0], 1'b0})) ^ {(WIDTH+2){d.sneg}};
endmodule

// File: rtl/tri_fu_mul_bthseq.sv
// tri_fu_mul_bthseq: iterative signed radix-4 Booth multiplier, ROWS digits per cycle, one op in flight
//   nclk  in  clock, rising edge
//   rst_b in  asynchronous active-low reset
//   bus   slave modport: flush, i_vld/i_rdy/i_a/i_b/(i_c), o_vld/o_rdy/o_p
//   Define TRI_FU_MUL_BTHSEQ_ACC_EN to seed the accumulator with i_c (o_p = a*b+c).
module tri_fu_mul_bthseq
  import tri_fu_mul_bthseq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROWS = 2
) (
  input logic nclk,
  input logic rst_b,
  tri_fu_mul_bthseq_if.slave bus
);
  localparam int NCYC = ncyc(WIDTH, ROWS);
  localparam int CW = NCYC > 1 ? $clog2(NCYC) : 1;
  localparam int PW = 2 * WIDTH;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH+1:0] a_reg;
  logic [WIDTH:0] m_reg;
  logic [PW-1:0] acc, add, acc_nxt, p_reg, seed;
  logic [WIDTH+1:0] rows [ROWS];
  logic [ROWS-1:0] snegs;
  logic last, accept;
`ifdef TRI_FU_MUL_BTHSEQ_ACC_EN
  assign seed = bus.i_c;
`else
  assign seed = '0;
`endif
  assign last = cnt == CW'(NCYC - 1);
  assign bus.i_rdy = (state == IDLE) | ((state == DONE) & bus.o_rdy);
  assign accept = bus.i_vld & bus.i_rdy & ~bus.flush;
  assign bus.o_vld = state == DONE;
  assign bus.o_p = p_reg;
  assign acc_nxt = acc + add;
  // m_reg keeps b[-1] at bit 0, so row r of this cycle reads its triplet at bits 2r+2:2r
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    tri_fu_mul_bthseq_bthrow #(.WIDTH(WIDTH)) u_row (
      .trip(m_reg[2*r+2:2*r]),
      .a(a_reg),
      .row(rows[r]),
      .sneg(snegs[r])
    );
  end
  always_comb begin
    add = '0;
    for (int r = 0; r < ROWS; r++)
      add = add + (({{(PW-WIDTH-2){rows[r][WIDTH+1]}}, rows[r]} + PW'(snegs[r])) << (2 * (int'(cnt) * ROWS + r)));
  end
  always_comb begin
    state_nxt = bus.flush ? IDLE
              : accept ? BUSY
              : (state == BUSY) ? (last ? DONE : BUSY)
              : ((state == DONE) & ~bus.o_rdy) ? DONE
              : IDLE;
  end
  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt <= '0;
      a_reg <= '0;
      m_reg <= '0;
      acc <= '0;
      p_reg <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg <= {{2{bus.i_a[WIDTH-1]}}, bus.i_a};
        m_reg <= {bus.i_b, 1'b0};
        acc <= seed;
        cnt <= '0;
      end else if ((state == BUSY) & ~bus.flush) begin
        acc <= acc_nxt;
        m_reg <= m_reg >> (2 * ROWS);
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) p_reg <= acc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_tri_fu_mul_bthseq.sv
// tb_tri_fu_mul_bthseq: table vectors, handshake corner sequences and random ops against an arithmetic model
module tb_tri_fu_mul_bthseq;
  localparam int W = 16;
  localparam int NCYC = 4;
  logic nclk = 1'b0;
  logic rst_b = 1'b0;
  logic [31:0] cval = '0;
  int errs = 0;
  int checks = 0;
  always #5 nclk = ~nclk;
  tri_fu_mul_bthseq_if #(.WIDTH(W)) bus ();
`ifdef TRI_FU_MUL_BTHSEQ_ACC_EN
  assign bus.i_c = cval;
`endif
  tri_fu_mul_bthseq #(.WIDTH(W), .ROWS(2)) dut (.nclk(nclk), .rst_b(rst_b), .bus(bus));
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t vt [10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b)) + longint'(c);
    return p[31:0];
  endfunction
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output logic [31:0] p, output int lat);
    bus.i_a = a;
    bus.i_b = b;
    bus.i_vld = 1'b1;
    @(posedge nclk);
    #1 bus.i_vld = 1'b0;
    lat = 0;
    while (!bus.o_vld && lat < 20) begin
      @(posedge nclk);
      #1 lat++;
    end
    p = bus.o_p;
  endtask
  initial begin
    logic [15:0] a, b;
    logic [31:0] p, hold;
    int lat;
    bit stable, seen;
    vt[0] = '{a: 16'h0003, b: 16'h0005, p: 32'h0000000F};
    vt[1] = '{a: 16'h8000, b: 16'h8000, p: 32'h40000000};
    vt[2] = '{a: 16'h8000, b: 16'h7FFF, p: 32'hC0008000};
    vt[3] = '{a: 16'h7FFF, b: 16'h7FFF, p: 32'h3FFF0001};
    vt[4] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'h00000001};
    vt[5] = '{a: 16'h0000, b: 16'h1234, p: 32'h00000000};
    vt[6] = '{a: 16'h0001, b: 16'hFFFF, p: 32'hFFFFFFFF};
    vt[7] = '{a: 16'hFFFF, b: 16'h8000, p: 32'h00008000};
    vt[8] = '{a: 16'h7FFF, b: 16'h8000, p: 32'hC0008000};
    vt[9] = '{a: 16'h0002, b: 16'h0003, p: 32'h00000006};
    bus.flush = 1'b0;
    bus.i_vld = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.o_rdy = 1'b1;
    #12;
    chk("rst_irdy", bus.i_rdy, 1);
    chk("rst_ovld", bus.o_vld, 0);
    chk("rst_op", bus.o_p, 0);
    rst_b = 1'b1;
    @(posedge nclk);
    #1;
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, p, lat);
      chk($sformatf("vec%0d_p", i), p, vt[i].p);
      chk($sformatf("vec%0d_lat", i), lat, NCYC);
      if (i == 0) chk("done_irdy", bus.i_rdy, 1);
    end
    @(posedge nclk);
    #1 chk("idle_after_take", bus.o_vld, 0);
    bus.o_rdy = 1'b0;
    run_op(16'h1234, 16'h0F0F, p, lat);
    chk("hold_p", p, model(16'h1234, 16'h0F0F, 32'h0));
    hold = p;
    stable = 1'b1;
    repeat (10) begin
      @(posedge nclk);
      #1 if (!bus.o_vld || bus.o_p !== hold || bus.i_rdy) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    bus.o_rdy = 1'b1;
    bus.i_a = 16'hFFFE;
    bus.i_b = 16'h0003;
    bus.i_vld = 1'b1;
    #1 chk("b2b_irdy", bus.i_rdy, 1);
    @(posedge nclk);
    #1 bus.i_vld = 1'b0;
    chk("b2b_ovld_drop", bus.o_vld, 0);
    repeat (3) @(posedge nclk);
    #1 chk("b2b_early", bus.o_vld, 0);
    @(posedge nclk);
    #1 chk("b2b_vld", bus.o_vld, 1);
    chk("b2b_p", bus.o_p, 32'hFFFFFFFA);
    @(posedge nclk);
    #1;
    bus.i_a = 16'h0100;
    bus.i_b = 16'h0100;
    bus.i_vld = 1'b1;
    @(posedge nclk);
    #1 bus.i_vld = 1'b0;
    @(posedge nclk);
    #1 bus.flush = 1'b1;
    @(posedge nclk);
    #1 bus.flush = 1'b0;
    chk("flush_irdy", bus.i_rdy, 1);
    chk("flush_ovld", bus.o_vld, 0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge nclk);
      #1 if (bus.o_vld) seen = 1'b1;
    end
    chk("flush_no_vld", seen, 0);
    bus.i_a = 16'h0005;
    bus.i_b = 16'h0005;
    bus.i_vld = 1'b1;
    bus.flush = 1'b1;
    @(posedge nclk);
    #1 bus.i_vld = 1'b0;
    bus.flush = 1'b0;
    chk("flush_acc_irdy", bus.i_rdy, 1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge nclk);
      #1 if (bus.o_vld) seen = 1'b1;
    end
    chk("flush_acc_no_vld", seen, 0);
    run_op(16'hFFFF, 16'hFFFF, p, lat);
    chk("post_flush_p", p, 32'h00000001);
    chk("post_flush_lat", lat, NCYC);
    @(posedge nclk);
    #1;
    bus.i_a = 16'h0007;
    bus.i_b = 16'h0009;
    bus.i_vld = 1'b1;
    @(posedge nclk);
    #1 bus.i_vld = 1'b0;
    @(posedge nclk);
    #2 rst_b = 1'b0;
    #1 chk("rst_mid_irdy", bus.i_rdy, 1);
    chk("rst_mid_ovld", bus.o_vld, 0);
    chk("rst_mid_op", bus.o_p, 0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge nclk);
      #1 if (bus.o_vld) seen = 1'b1;
    end
    rst_b = 1'b1;
    repeat (6) begin
      @(posedge nclk);
      #1 if (bus.o_vld) seen = 1'b1;
    end
    chk("rst_mid_no_vld", seen, 0);
`ifdef TRI_FU_MUL_BTHSEQ_ACC_EN
    cval = 32'hFFFFFFFF;
    run_op(16'h0002, 16'h0003, p, lat);
    chk("acc_p", p, 32'h00000005);
    cval = '0;
    @(posedge nclk);
    #1;
`endif
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
`ifdef TRI_FU_MUL_BTHSEQ_ACC_EN
      cval = $urandom;
`endif
      run_op(a, b, p, lat);
      chk($sformatf("rand%0d a=%h b=%h", i, a, b), p, model(a, b, cval));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
